// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: instruction register fed by a DEPTH-entry prefetch FIFO; define IR_BYPASS_EN for empty-queue load bypass
module ir_prefetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int OPW   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       ir_wre,
    output logic [WIDTH-1:0]           ir_out,
    output logic                       ir_valid,
    output logic [OPW-1:0]             op,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ir_out_q, ir_out_d;
    logic             ir_valid_q, ir_valid_d, underflow_q, underflow_d;
    logic             push, load, have, bypass, pop, wr_en;
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign in_ready  = !full && !flush && !rst;
    assign count     = count_q;
    assign ir_out    = ir_out_q;
    assign ir_valid  = ir_valid_q;
    assign underflow = underflow_q;
    assign op        = ir_out_q[WIDTH-1 -: OPW];
    always_comb begin
        push   = in_valid && in_ready;
        load   = ir_wre && !flush;
        have   = !empty;
`ifdef IR_BYPASS_EN
        bypass = load && !have && push;
`else
        bypass = 1'b0;
`endif
        pop    = load && have;
        wr_en  = push && !bypass;
        rd_ptr_d    = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d    = flush ? '0 : wr_ptr_q + AW'(wr_en);
        count_d     = flush ? '0 : count_q + CW'(wr_en) - CW'(pop);
        ir_out_d    = pop ? mem_q[rd_ptr_q] : bypass ? in_data : ir_out_q;
        ir_valid_d  = flush ? 1'b0 : (pop || bypass) ? 1'b1 : load ? 1'b0 : ir_valid_q;
        underflow_d = underflow_q || (load && !have && !bypass);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ir_out_q    <= '0;
            ir_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ir_out_q    <= ir_out_d;
            ir_valid_q  <= ir_valid_d;
            underflow_q <= underflow_d;
        end
    end
    // queue storage needs no reset; wr_en is already blocked during rst and flush
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue: directed checks of ir_prefetch_queue, DEPTH=4, both IR_BYPASS_EN builds
module tb_ir_prefetch_queue;
    logic        clk, rst, flush, in_valid, in_ready, ir_wre, ir_valid, empty, full, underflow;
    logic [31:0] in_data, ir_out;
    logic [5:0]  op;
    logic [2:0]  count;
    int tests = 0;
    int fails = 0;

    ir_prefetch_queue #(.WIDTH(32), .DEPTH(4), .OPW(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ir_wre(ir_wre), .ir_out(ir_out), .ir_valid(ir_valid),
        .op(op), .count(count), .empty(empty), .full(full), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; ir_wre = 1'b0;
        step();
        step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_ir_out", ir_out, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_empty", {31'b0, empty}, 32'd1);
        chk("idle_full", {31'b0, full}, 32'd0);
        chk("idle_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("idle_underflow", {31'b0, underflow}, 32'd0);
        chk("idle_op", {26'b0, op}, 32'd0);

        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h1111_1111 * i;
            step();
        end
        chk("fill_count", {29'b0, count}, 32'd4);
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
        in_data = 32'h5555_5555;
        step();
        chk("fifth_refused", {29'b0, count}, 32'd4);
        in_valid = 1'b0;
        ir_wre = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_ir_out", ir_out, 32'h1111_1111 * i);
            if (i == 1) chk("drain_op", {26'b0, op}, 32'h04);
        end
        ir_wre = 1'b0;
        chk("drain_empty", {31'b0, empty}, 32'd1);
        chk("drain_ir_valid", {31'b0, ir_valid}, 32'd1);

        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 32'hA000_0000 + k;
            step();
        end
        ir_wre = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 32'hA000_0002 + k;
            step();
            chk("wrap_ir_out", ir_out, 32'hA000_0000 + k);
            chk("wrap_count", {29'b0, count}, 32'd2);
        end
        ir_wre = 1'b0;
        in_data = 32'hA000_000C;
        step();
        chk("preflush_count", {29'b0, count}, 32'd3);

        flush = 1'b1; ir_wre = 1'b1; in_data = 32'hDEAD_BEEF;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0; ir_wre = 1'b0; in_valid = 1'b0;
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("flush_ir_out", ir_out, 32'hA000_0009);
        chk("flush_underflow", {31'b0, underflow}, 32'd0);
        in_valid = 1'b1; in_data = 32'h1234_5678;
        step();
        in_valid = 1'b0; ir_wre = 1'b1;
        step();
        chk("postflush_ir_out", ir_out, 32'h1234_5678);
        chk("postflush_count", {29'b0, count}, 32'd0);

        step();
        ir_wre = 1'b0;
        chk("eload_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("eload_underflow", {31'b0, underflow}, 32'd1);
        chk("eload_ir_out", ir_out, 32'h1234_5678);
        in_valid = 1'b1; in_data = 32'hCAFE_F00D;
        step();
        in_valid = 1'b0; ir_wre = 1'b1;
        step();
        ir_wre = 1'b0;
        chk("sticky_ir_out", ir_out, 32'hCAFE_F00D);
        chk("sticky_ir_valid", {31'b0, ir_valid}, 32'd1);
        chk("sticky_underflow", {31'b0, underflow}, 32'd1);

        in_valid = 1'b1; in_data = 32'h0BAD_0BAD;
        step();
        rst = 1'b1; flush = 1'b1; ir_wre = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; ir_wre = 1'b0; in_valid = 1'b0;
        chk("midrst_count", {29'b0, count}, 32'd0);
        chk("midrst_ir_out", ir_out, 32'd0);
        chk("midrst_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("midrst_underflow", {31'b0, underflow}, 32'd0);

        in_valid = 1'b1; ir_wre = 1'b1; in_data = 32'h8C01_0004;
        step();
        in_valid = 1'b0; ir_wre = 1'b0;
`ifdef IR_BYPASS_EN
        chk("byp_ir_out", ir_out, 32'h8C01_0004);
        chk("byp_ir_valid", {31'b0, ir_valid}, 32'd1);
        chk("byp_op", {26'b0, op}, 32'h23);
        chk("byp_count", {29'b0, count}, 32'd0);
        chk("byp_underflow", {31'b0, underflow}, 32'd0);
`else
        chk("nobyp_count", {29'b0, count}, 32'd1);
        chk("nobyp_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("nobyp_underflow", {31'b0, underflow}, 32'd1);
        chk("nobyp_ir_out", ir_out, 32'd0);
        ir_wre = 1'b1;
        step();
        ir_wre = 1'b0;
        chk("nobyp_late_load", ir_out, 32'h8C01_0004);
        chk("nobyp_late_op", {26'b0, op}, 32'h23);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ir_prefetch_queue.md
# ir_prefetch_queue

Parametrised instruction register with an integrated prefetch FIFO, sitting between instruction memory and the control unit of the multicycle CPU. Fetched words are buffered in a DEPTH-entry queue. A load strobe moves the queue head into the architectural instruction register, which holds its value between loads. A flush input discards all prefetched words on a taken branch or jump.

## Interface
Parameters:
- WIDTH, 32, instruction word width in bits (≥ 8)
- DEPTH, 4, queue entries; power of two, ≥ 2
- OPW, 6, opcode field width; opcode is ir_out[WIDTH-1 -: OPW]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard queue contents, clear ir_valid
- in_valid  in  1  instruction memory presents a word
- in_data  in  WIDTH  fetched instruction word
- in_ready  out  1  queue accepts a word this cycle
- ir_wre  in  1  load strobe: move queue head into ir_out
- ir_out  out  WIDTH  instruction register contents
- ir_valid  out  1  ir_out holds a word loaded since the last flush/reset
- op  out  OPW  opcode field of ir_out, combinational slice
- count  out  $clog2(DEPTH)+1  current queue occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- underflow  out  1  sticky error: load attempted with nothing to load

## Operation
- Push occurs when in_valid && in_ready.
  - Word written at wr_ptr; wr_ptr += 1 mod DEPTH.
- in_ready = !full && !flush && !rst, combinational from registered state only.
  - No dependence on ir_wre: a full queue refuses a push even when popping in the same cycle.
- Load (ir_wre=1, flush=0) with queue non-empty:
  - ir_out <= mem[rd_ptr]; rd_ptr += 1 mod DEPTH; ir_valid <= 1.
- Load with queue empty and no bypass:
  - ir_out holds, ir_valid <= 0, underflow <= 1.
  - underflow clears only on rst.
- ir_wre=0: ir_out and ir_valid hold.
- Simultaneous push and load on a non-empty queue: both take effect; count unchanged.
- Flush:
  - rd_ptr, wr_ptr and count go to 0; ir_valid <= 0; ir_out keeps its last value.
  - Any push or load in the same cycle is ignored (flush has priority).
  - underflow is not set by a load ignored under flush.
- Pointers wrap modulo DEPTH; count alone distinguishes full from empty.
- Reset, including mid-operation: ir_out=0, ir_valid=0, count=0, pointers=0, underflow=0.
  - Reset overrides flush, push and load.
  - Queue RAM contents are don't-care after reset.

## Timing
- Reset values: ir_out=0, op=0, ir_valid=0, count=0, empty=1, full=0, underflow=0, in_ready=0 while rst=1 and 1 in the first cycle after.
- Pushed word is at the queue head on the next edge.
- ir_out/ir_valid update on the edge where ir_wre is sampled.
- Minimum push-to-ir_out latency: 2 edges without bypass, 1 edge with bypass.
- Throughput: one push and one load per cycle sustained while 0 < count < DEPTH.
- count, empty and full are registered and reflect all events of the previous edge.

## Configuration
- IR_BYPASS_EN defined: a load in a cycle where count == 0 and a push occurs loads in_data directly.
  - ir_out <= in_data, ir_valid <= 1.
  - The word is not written into the queue; count stays 0; underflow not set.
- IR_BYPASS_EN undefined: the same cycle writes in_data into the queue (count → 1).
  - The load is an empty-load: ir_valid <= 0, underflow <= 1.

## Test plan
- Reset then idle:
  - Hold rst 2 cycles, then release → ir_out=0, ir_valid=0, count=0, empty=1, in_ready=1, underflow=0.
- Fill and drain, DEPTH=4:
  - Push 0x11111111..0x44444444 on 4 edges → full=1, in_ready=0.
  - 5th word 0x55555555 is not accepted.
  - 4 loads → ir_out sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444; op=0x04 on the first; empty=1 at end.
- Wrap-around with concurrent push/load:
  - Preload 2 words, then 10 cycles of simultaneous push and load → count stays 2.
  - ir_out follows push order exactly across pointer wrap.
- Flush priority:
  - count=3; assert flush with in_valid=1 and ir_wre=1 → next cycle count=0, ir_valid=0, ir_out unchanged, pushed word absent from queue.
- Empty load:
  - count=0, ir_wre=1, in_valid=0 → ir_valid=0, underflow=1.
  - underflow stays 1 after subsequent good loads until rst.
- Bypass:
  - count=0, ir_wre=1, in_valid=1, in_data=0x8C010004.
  - With IR_BYPASS_EN: next cycle ir_out=0x8C010004, ir_valid=1, op=0x23, count=0.
  - Without IR_BYPASS_EN: count=1, ir_valid=0, underflow=1.
